// File: rtl/debounce_sync.sv
// Input conditioner: multi-flop synchronizer followed by a stability-counter debouncer.
// Produces a clean level, one-cycle rise/fall pulses and a qualification-in-progress flag.
module debounce_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_CYCLES   = 4,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic data_in,
    output logic data_out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int             CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q_s;
    logic                   mismatch_s;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   data_out_r;
    logic                   data_nxt_s;
    logic                   rise_r;
    logic                   rise_nxt_s;
    logic                   fall_r;
    logic                   fall_nxt_s;

    // Plain flop chain; nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], data_in};
        end
    end

    assign sync_q_s   = sync_r[SYNC_STAGES-1];
    assign mismatch_s = (sync_q_s != data_out_r);

    // Next-state logic: count consecutive mismatching edges, commit on the last one.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        data_nxt_s  = data_out_r;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mismatch_s) begin
                    // With a one-edge window the first mismatch already qualifies.
                    if (CNT_LAST == CNT_ZERO) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                        data_nxt_s  = sync_q_s;
                        rise_nxt_s  = sync_q_s;
                        fall_nxt_s  = ~sync_q_s;
                    end else begin
                        state_nxt_s = ST_CHECK;
                        cnt_nxt_s   = CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = CNT_ZERO;
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                        data_nxt_s  = sync_q_s;
                        rise_nxt_s  = sync_q_s;
                        fall_nxt_s  = ~sync_q_s;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    // Bounced back before qualifying: discard the candidate.
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            data_out_r <= RESET_LEVEL;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            data_out_r <= data_nxt_s;
            rise_r     <= rise_nxt_s;
            fall_r     <= fall_nxt_s;
        end
    end

    assign data_out = data_out_r;
    assign rise     = rise_r;
    assign fall     = fall_r;
    assign busy     = mismatch_s;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync (SYNC_STAGES=2, DB_CYCLES=4, RESET_LEVEL=0).
// Outputs are compared as {data_out, rise, fall, busy} 1 time unit after each rising edge.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic reset;
    logic data_in;
    logic data_out;
    logic rise;
    logic fall;
    logic busy;

    int total = 0;
    int bad   = 0;

    debounce_sync #(
        .SYNC_STAGES(2),
        .DB_CYCLES  (4),
        .RESET_LEVEL(1'b0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .data_out(data_out),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset   = 1'b0;
        data_in = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        reset   = 1'b0;
        data_in = 1'b1;
        #3;
        total++;
        if ({data_out, rise, fall, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_async got=%b exp=%b", {data_out, rise, fall, busy}, 4'b0000);
        end
        repeat (2) step();
        total++;
        if ({data_out, rise, fall, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_held got=%b exp=%b", {data_out, rise, fall, busy}, 4'b0000);
        end
        reset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp = {(e >= 6), (e == 6), 1'b0, (e >= 2 && e < 6)};
            total++;
            if ({data_out, rise, fall, busy} !== exp) begin
                bad++;
                $display("FAIL reset_release e=%0d got=%b exp=%b", e, {data_out, rise, fall, busy}, exp);
            end
        end
    endtask

    task automatic test_clean_step();
        logic [3:0] exp;
        apply_reset();
        data_in = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            exp = {(e >= 6), (e == 6), 1'b0, (e >= 2 && e < 6)};
            total++;
            if ({data_out, rise, fall, busy} !== exp) begin
                bad++;
                $display("FAIL clean_step e=%0d got=%b exp=%b", e, {data_out, rise, fall, busy}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp;
        // Three-cycle pulse: only three mismatching edges, never qualifies.
        apply_reset();
        for (int e = 1; e <= 12; e++) begin
            data_in = (e <= 3);
            step();
            exp = {1'b0, 1'b0, 1'b0, (e >= 2 && e <= 4)};
            total++;
            if ({data_out, rise, fall, busy} !== exp) begin
                bad++;
                $display("FAIL glitch3 e=%0d got=%b exp=%b", e, {data_out, rise, fall, busy}, exp);
            end
        end
        // Four-cycle pulse qualifies at edge 6, and its trailing 0 qualifies a fall at edge 10.
        apply_reset();
        for (int e = 1; e <= 12; e++) begin
            data_in = (e <= 4);
            step();
            exp = {(e >= 6 && e < 10), (e == 6), (e == 10), ((e >= 2 && e < 6) || (e >= 6 && e < 10))};
            total++;
            if ({data_out, rise, fall, busy} !== exp) begin
                bad++;
                $display("FAIL glitch4 e=%0d got=%b exp=%b", e, {data_out, rise, fall, busy}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp;
        apply_reset();
        for (int e = 1; e <= 12; e++) begin
            data_in = (e != 2);
            step();
            exp = {(e >= 8), (e == 8), 1'b0, (e == 2 || (e >= 4 && e < 8))};
            total++;
            if ({data_out, rise, fall, busy} !== exp) begin
                bad++;
                $display("FAIL bounce e=%0d got=%b exp=%b", e, {data_out, rise, fall, busy}, exp);
            end
        end
    endtask

    task automatic test_fall();
        logic [3:0] exp;
        // Starts from data_out=1 with data_in=1 left by test_bounce.
        for (int e = 1; e <= 30; e++) begin
            data_in = (e == 16);
            step();
            exp = {(e < 6), 1'b0, (e == 6), ((e >= 2 && e < 6) || e == 17)};
            total++;
            if ({data_out, rise, fall, busy} !== exp) begin
                bad++;
                $display("FAIL fall e=%0d got=%b exp=%b", e, {data_out, rise, fall, busy}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_check();
        apply_reset();
        data_in = 1'b1;
        repeat (4) step();
        total++;
        if ({data_out, rise, fall, busy} !== 4'b0001) begin
            bad++;
            $display("FAIL midcheck_pre got=%b exp=%b", {data_out, rise, fall, busy}, 4'b0001);
        end
        #2;
        reset   = 1'b0;
        data_in = 1'b0;
        #1;
        total++;
        if ({data_out, rise, fall, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL midcheck_async got=%b exp=%b", {data_out, rise, fall, busy}, 4'b0000);
        end
        step();
        reset = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            total++;
            if ({data_out, rise, fall, busy} !== 4'b0000) begin
                bad++;
                $display("FAIL midcheck_after e=%0d got=%b exp=%b", e, {data_out, rise, fall, busy}, 4'b0000);
            end
        end
    endtask

    task automatic test_reset_during_pulse();
        apply_reset();
        data_in = 1'b1;
        repeat (6) step();
        total++;
        if ({data_out, rise, fall, busy} !== 4'b1100) begin
            bad++;
            $display("FAIL pulse_pre got=%b exp=%b", {data_out, rise, fall, busy}, 4'b1100);
        end
        #2;
        reset   = 1'b0;
        data_in = 1'b0;
        #1;
        total++;
        if ({data_out, rise, fall, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL pulse_async got=%b exp=%b", {data_out, rise, fall, busy}, 4'b0000);
        end
        step();
        reset = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            total++;
            if ({data_out, rise, fall, busy} !== 4'b0000) begin
                bad++;
                $display("FAIL pulse_after e=%0d got=%b exp=%b", e, {data_out, rise, fall, busy}, 4'b0000);
            end
        end
    endtask

    task automatic test_toggle();
        apply_reset();
        for (int e = 1; e <= 20; e++) begin
            data_in = e[0];
            step();
            total++;
            if ({data_out, rise, fall} !== 3'b000) begin
                bad++;
                $display("FAIL toggle e=%0d got=%b exp=%b", e, {data_out, rise, fall}, 3'b000);
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        data_in = 1'b0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_fall();
        test_reset_mid_check();
        test_reset_during_pulse();
        test_toggle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
